// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem request FSM,
// one-entry pending buffer for stalled responses, and the IF/ID register.
module instr_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc_plus4,
   output logic [5:0]  instr_op,
   output logic [5:0]  instruction_5_0
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;

   localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

   state_t      state, state_n;
   logic [31:0] pc, pc_n, pc_inc;
   logic [31:0] pend_instr, pend_instr_n, pend_pc4, pend_pc4_n;
   logic        valid_n;
   logic [31:0] instr_n, pc4_n;
   logic        resp;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pc          <= PC_INIT;
         pend_instr  <= '0;
         pend_pc4    <= '0;
         if_valid    <= 1'b0;
         if_instr    <= '0;
         if_pc_plus4 <= '0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         pend_instr  <= pend_instr_n;
         pend_pc4    <= pend_pc4_n;
         if_valid    <= valid_n;
         if_instr    <= instr_n;
         if_pc_plus4 <= pc4_n;
      end
   end

   assign pc_inc = pc + 32'd4;
   assign resp   = (state == REQ) && imem_ready;

   // Priority: branch > flush > stall > normal fetch. A response that lands
   // under flush still retires its address so the next fetch moves on.
   always_comb begin
      state_n      = state;
      pc_n         = pc;
      pend_instr_n = pend_instr;
      pend_pc4_n   = pend_pc4;
      valid_n      = if_valid;
      instr_n      = if_instr;
      pc4_n        = if_pc_plus4;
      if (branch_taken) begin
         pc_n         = branch_target & 32'hFFFF_FFFC;
         valid_n      = 1'b0;
         instr_n      = '0;
         pend_instr_n = '0;
         pend_pc4_n   = '0;
         state_n      = REQ;
      end else if (flush) begin
         if (resp) pc_n = pc_inc;
         valid_n      = 1'b0;
         instr_n      = '0;
         pend_instr_n = '0;
         pend_pc4_n   = '0;
         state_n      = REQ;
      end else begin
         case (state)
            IDLE: state_n = REQ;
            REQ: begin
               if (imem_ready) begin
                  pc_n = pc_inc;
                  if (stall) begin
                     pend_instr_n = imem_rdata;
                     pend_pc4_n   = pc_inc;
                     state_n      = HOLD;
                  end else begin
                     valid_n = 1'b1;
                     instr_n = imem_rdata;
                     pc4_n   = pc_inc;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  valid_n = 1'b1;
                  instr_n = pend_instr;
                  pc4_n   = pend_pc4;
                  state_n = REQ;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign imem_req        = (state == REQ);
   assign imem_addr       = pc;
   assign instr_op        = if_instr[31:26];
   assign instruction_5_0 = if_instr[5:0];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: expected IF/ID contents are queued as
// responses are driven; a negedge monitor pops them whenever IF/ID presents a new instruction.
module tb_instr_fetch_stage;

   logic        clk, reset, stall, flush, branch_taken, imem_ready;
   logic [31:0] branch_target, imem_rdata;
   logic        imem_req, if_valid;
   logic [31:0] imem_addr, if_instr, if_pc_plus4;
   logic [5:0]  instr_op, instruction_5_0;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_instr, w_pc4;
   logic [5:0]  w_op, w_fn;

   int checks = 0;
   int failures = 0;

   typedef struct { logic [31:0] instr; logic [31:0] pc4; } exp_t;
   exp_t sb[$];

   instr_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr),
      .if_pc_plus4(if_pc_plus4), .instr_op(instr_op), .instruction_5_0(instruction_5_0));

   instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .if_valid(w_valid), .if_instr(w_instr),
      .if_pc_plus4(w_pc4), .instr_op(w_op), .instruction_5_0(w_fn));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
      exp_t e;
      e.instr = instr;
      e.pc4   = pc4;
      sb.push_back(e);
   endtask

   // Monitor: a new IF/ID presentation is a rising if_valid or changed contents.
   logic        prev_v;
   logic [31:0] prev_i, prev_p;
   always @(negedge clk) begin
      if (!reset) begin
         prev_v = 1'b0;
      end else begin
         if (if_valid && (!prev_v || if_instr != prev_i || if_pc_plus4 != prev_p)) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected", if_instr, 32'hDEAD_BEEF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_instr", if_instr, e.instr);
               chk("sb_pc4", if_pc_plus4, e.pc4);
            end
         end
         prev_v = if_valid;
      end
      prev_i = if_instr;
      prev_p = if_pc_plus4;
   end

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
      branch_target = '0; imem_ready = 1'b0; imem_rdata = '0;
      #2 reset = 1'b0;
      #1;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      chk("rst_pc4", if_pc_plus4, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
      step(); step();
      reset = 1'b1;
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      step();

      // streaming fetch: lw at 0
      chk("req0", {31'd0, imem_req}, 32'd1);
      chk("addr0", imem_addr, 32'd0);
      chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      imem_ready = 1'b1; imem_rdata = 32'h8C00_0000; push(32'h8C00_0000, 32'd4);
      step();
      chk("lw_op", {26'd0, instr_op}, 32'h23);
      chk("lw_pc4", if_pc_plus4, 32'd4);
      chk("addr4", imem_addr, 32'd4);
      chk("wrap_addr1", w_addr, 32'd0);

      // three wait states at addr 4
      imem_ready = 1'b0; imem_rdata = 32'h5555_5555;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, 32'd4);
         chk("wait_valid", {31'd0, if_valid}, 32'd1);
         chk("wait_instr", if_instr, 32'h8C00_0000);
      end
      imem_ready = 1'b1; imem_rdata = 32'h0000_0020; push(32'h0000_0020, 32'd8);
      step();
      chk("add_op", {26'd0, instr_op}, 32'd0);
      chk("add_fn", {26'd0, instruction_5_0}, 32'h20);
      chk("add_pc4", if_pc_plus4, 32'd8);
      chk("addr8", imem_addr, 32'd8);

      // stall capture of sw at addr 8
      stall = 1'b1; imem_rdata = 32'hAC00_0000; push(32'hAC00_0000, 32'd12);
      step();
      imem_ready = 1'b0;
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_instr", if_instr, 32'h0000_0020);
      step();
      chk("hold_req2", {31'd0, imem_req}, 32'd0);
      chk("hold_pc4", if_pc_plus4, 32'd8);
      stall = 1'b0;
      step();
      chk("sw_op", {26'd0, instr_op}, 32'h2B);
      chk("req_after_hold", {31'd0, imem_req}, 32'd1);
      chk("addr12", imem_addr, 32'd12);

      // flush alone with a response in flight: data dropped, pc still advances
      flush = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h1111_1111;
      step();
      flush = 1'b0;
      chk("flush_valid", {31'd0, if_valid}, 32'd0);
      chk("flush_instr", if_instr, 32'd0);
      chk("flush_addr", imem_addr, 32'd16);
      imem_rdata = 32'h2222_2222; push(32'h2222_2222, 32'd20);
      step();
      chk("flush_bubble1", {31'd0, if_valid}, 32'd1);

      // branch beats flush and drops the returned data
      branch_taken = 1'b1; flush = 1'b1; branch_target = 32'h0000_0103;
      imem_rdata = 32'h3333_3333;
      step();
      branch_taken = 1'b0; flush = 1'b0;
      chk("br_addr", imem_addr, 32'h0000_0100);
      chk("br_valid", {31'd0, if_valid}, 32'd0);
      chk("br_op", {26'd0, instr_op}, 32'd0);
      imem_rdata = 32'h4444_4444; push(32'h4444_4444, 32'h0000_0104);
      step();
      chk("br_pc4", if_pc_plus4, 32'h0000_0104);

      // branch during a wait state redirects the pending request
      imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0202;
      step();
      branch_taken = 1'b0;
      chk("brw_addr", imem_addr, 32'h0000_0200);
      step();
      chk("brw_stable", imem_addr, 32'h0000_0200);
      chk("brw_req", {31'd0, imem_req}, 32'd1);

      // asynchronous reset mid-wait
      #2 reset = 1'b0;
      #1;
      chk("arst_req", {31'd0, imem_req}, 32'd0);
      chk("arst_valid", {31'd0, if_valid}, 32'd0);
      chk("arst_instr", if_instr, 32'd0);
      chk("arst_pc4", if_pc_plus4, 32'd0);
      chk("arst_addr", imem_addr, 32'd0);
      step();
      reset = 1'b1;
      step();
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);
      chk("post_rst_addr", imem_addr, 32'd0);

      step();
      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
